dsp_mac_signed_param: RTL and testbench
=======================================

# dsp_mac_signed_param

Parametrised signed multiply-accumulate block: next generation of the fixed 20x18 signed MAC with add/subtract accumulation. Widths are generic, input and output registers are selectable, and it adds a qualifying valid, a synchronous accumulator clear/load, optional saturation and a sticky overflow flag. It sits in the DSP test designs as the reference MAC for mapping onto the hard DSP block's multiplier, accumulator and pipeline-register options.

## Interface
- A_WIDTH, 20, signed width of operand A
- B_WIDTH, 18, signed width of operand B
- ACC_WIDTH, 40, accumulator/result width; must be >= A_WIDTH+B_WIDTH
- IN_REG, 0, 1 = register A, B, subtract_i, clear_i, valid_i before the multiplier
- OUT_REG, 0, 1 = register P, overflow_o, valid_o after the accumulator
- SATURATE, 0, 1 = clamp on overflow; 0 = two's-complement wrap
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- subtract_i  input  1  0: acc + A*B; 1: acc - A*B
- clear_i  input  1  synchronous accumulator restart (see Operation)
- valid_i  input  1  qualifies A/B; acc holds when low
- A  input  A_WIDTH  signed operand
- B  input  B_WIDTH  signed operand
- P  output  ACC_WIDTH  signed accumulator value
- overflow_o  output  1  sticky overflow/saturation flag
- valid_o  output  1  P reflects an accepted update

## Operation
- Product: full-precision signed A*B, PW = A_WIDTH+B_WIDTH bits, sign-extended to ACC_WIDTH. The product never overflows PW.
- Per accepted cycle, with valid = valid_i after the optional input register:
  - clear=1, valid=1: acc <= +/-product; overflow_o <= 0. Load cannot overflow.
  - clear=1, valid=0: acc <= 0; overflow_o <= 0.
  - clear=0, valid=1: acc <= acc +/- product.
  - clear=0, valid=0: acc holds; overflow_o holds.
- Sum is formed in ACC_WIDTH+1 bits. Overflow = the result does not fit ACC_WIDTH signed.
  - SATURATE=1: clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - In both modes overflow_o is set and stays set until clear or reset.
- P equals acc. With OUT_REG=0 it is a direct wire from the acc register, with no extra flop.

## Timing
- Reset: acc, input regs, output regs, P, overflow_o and valid_o are all 0 asynchronously. Asserting reset mid-accumulation discards everything. The first edge after release behaves as from power-up.
- Latency from input sample to P, in rising edges, is 1 + IN_REG + OUT_REG. With defaults, inputs set before edge n appear on P after edge n.
- valid_o is valid_i delayed by the same latency. P and overflow_o change only on edges.
- Back-to-back valid cycles are accepted every cycle; there is no backpressure.
- subtract_i and clear_i are sampled in the same cycle as their A/B and travel with them through IN_REG.

## Structure
- Package dsp_mac_pkg:
  - function acc_max(width) and acc_min(width)
  - parameter-check macro/assertion for ACC_WIDTH >= A_WIDTH+B_WIDTH and for IN_REG, OUT_REG, SATURATE being 0/1
- Sub-module dsp_mac_sat_addsub: combinational ACC_WIDTH add/sub with overflow detect and clamp. Inputs: acc, extended product, subtract, SATURATE. Outputs: next value, ovf.
- Top holds the optional input stage, the multiplier, the acc/overflow registers and the optional output stage via generate.

## Test plan
- Reset: drive A=5, B=2, valid_i=1 while reset=1 for 2 edges -> P=0, overflow_o=0, valid_o=0. Assert reset mid-run at P=1000 -> P=0 immediately, before the next edge.
- Default params, subtract_i=0, A=5, B=2 for 3 valid cycles -> P = 10, 20, 30 on successive edges. Then subtract_i=1 for one cycle -> P=20.
- clear_i=1 with A=-3, B=7, subtract_i=1 -> P=21, overflow_o=0. Next cycle valid_i=0, clear_i=1 -> P=0. Then valid_i=0 for 3 cycles -> P holds 0.
- A_WIDTH=4, B_WIDTH=4, ACC_WIDTH=8, SATURATE=1: A=-8, B=-8 for 2 cycles -> P=64, then 127, with overflow_o=1. Subtract A=7, B=7 -> P=78, overflow_o still 1.
- Same widths with SATURATE=0 -> P=64, then -128, with overflow_o=1.
- IN_REG=1, OUT_REG=1, 32 random signed A/B with random subtract_i and valid_i -> P and valid_o match the model exactly 3 edges after each sample.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// Shared helpers for the parametrised signed MAC: accumulator limits and parameter legality.
package dsp_mac_pkg;

   localparam int unsigned LIMIT_W = 128;

   // Largest positive two's-complement value of the given width, zero-extended to LIMIT_W.
   function automatic logic [LIMIT_W-1:0] acc_max(input int unsigned width);
      return (LIMIT_W'(1) << (width - 1)) - LIMIT_W'(1);
   endfunction

   // Most negative value of the given width; truncating to width yields 100..0.
   function automatic logic [LIMIT_W-1:0] acc_min(input int unsigned width);
      return LIMIT_W'(1) << (width - 1);
   endfunction

   function automatic bit params_ok(input int unsigned a_w, input int unsigned b_w,
                                    input int unsigned acc_w, input int unsigned in_reg,
                                    input int unsigned out_reg, input int unsigned sat);
      return (acc_w >= a_w + b_w) && (acc_w <= LIMIT_W) &&
             (in_reg <= 1) && (out_reg <= 1) && (sat <= 1);
   endfunction

endpackage

// File: rtl/dsp_mac_sat_addsub.sv
// Combinational accumulator add/subtract with one guard bit, overflow detect and optional clamp.
module dsp_mac_sat_addsub
   import dsp_mac_pkg::*;
#(
   parameter int unsigned WIDTH    = 40,
   parameter int unsigned SATURATE = 0
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] prod,
   input  logic             subtract,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(acc_max(WIDTH));
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(acc_min(WIDTH));

   logic [WIDTH:0] acc_x;
   logic [WIDTH:0] prod_x;
   logic [WIDTH:0] sum;

   // Overflow when the guard bit disagrees with the result sign bit.
   always_comb begin
      acc_x  = {acc[WIDTH-1], acc};
      prod_x = {prod[WIDTH-1], prod};
      sum    = subtract ? (acc_x - prod_x) : (acc_x + prod_x);
      ovf    = sum[WIDTH] ^ sum[WIDTH-1];
      result = sum[WIDTH-1:0];
      if ((SATURATE != 0) && ovf) begin
         result = sum[WIDTH] ? MIN_V : MAX_V;
      end
   end

endmodule

// File: rtl/dsp_mac_signed_param.sv
// Parametrised signed multiply-accumulate with optional input/output pipeline registers.
module dsp_mac_signed_param
   import dsp_mac_pkg::*;
#(
   parameter int unsigned A_WIDTH   = 20,
   parameter int unsigned B_WIDTH   = 18,
   parameter int unsigned ACC_WIDTH = 40,
   parameter int unsigned IN_REG    = 0,
   parameter int unsigned OUT_REG   = 0,
   parameter int unsigned SATURATE  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 subtract_i,
   input  logic                 clear_i,
   input  logic                 valid_i,
   input  logic [A_WIDTH-1:0]   A,
   input  logic [B_WIDTH-1:0]   B,
   output logic [ACC_WIDTH-1:0] P,
   output logic                 overflow_o,
   output logic                 valid_o
);

   localparam int unsigned PW = A_WIDTH + B_WIDTH;

   generate
      if (!params_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, IN_REG, OUT_REG, SATURATE)) begin : g_bad_params
         $error("dsp_mac_signed_param: illegal parameter combination");
      end
   endgenerate

   logic signed [A_WIDTH-1:0] a_s;
   logic signed [B_WIDTH-1:0] b_s;
   logic                      sub_s;
   logic                      clr_s;
   logic                      vld_s;

   // Control bits travel with their operands through the optional input stage.
   generate
      if (IN_REG != 0) begin : g_in_reg
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_s   <= '0;
               b_s   <= '0;
               sub_s <= 1'b0;
               clr_s <= 1'b0;
               vld_s <= 1'b0;
            end else begin
               a_s   <= A;
               b_s   <= B;
               sub_s <= subtract_i;
               clr_s <= clear_i;
               vld_s <= valid_i;
            end
         end
      end else begin : g_in_wire
         assign a_s   = A;
         assign b_s   = B;
         assign sub_s = subtract_i;
         assign clr_s = clear_i;
         assign vld_s = valid_i;
      end
   endgenerate

   logic signed [PW-1:0]   prod;
   logic [ACC_WIDTH-1:0]   prod_ext;
   logic [ACC_WIDTH-1:0]   load_val;
   logic [ACC_WIDTH-1:0]   acc;
   logic                   ovf;
   logic                   acc_vld;
   logic [ACC_WIDTH-1:0]   sum;
   logic                   sum_ovf;

   assign prod     = PW'(a_s) * PW'(b_s);
   assign prod_ext = ACC_WIDTH'(prod);
   assign load_val = sub_s ? (ACC_WIDTH'(0) - prod_ext) : prod_ext;

   dsp_mac_sat_addsub #(
      .WIDTH    (ACC_WIDTH),
      .SATURATE (SATURATE)
   ) u_addsub (
      .acc      (acc),
      .prod     (prod_ext),
      .subtract (sub_s),
      .result   (sum),
      .ovf      (sum_ovf)
   );

   // Accumulator: clear has priority, a load cannot overflow, the flag is sticky until clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         ovf     <= 1'b0;
         acc_vld <= 1'b0;
      end else begin
         acc_vld <= vld_s;
         if (clr_s) begin
            acc <= vld_s ? load_val : '0;
            ovf <= 1'b0;
         end else if (vld_s) begin
            acc <= sum;
            ovf <= ovf | sum_ovf;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               P          <= '0;
               overflow_o <= 1'b0;
               valid_o    <= 1'b0;
            end else begin
               P          <= acc;
               overflow_o <= ovf;
               valid_o    <= acc_vld;
            end
         end
      end else begin : g_out_wire
         assign P          = acc;
         assign overflow_o = ovf;
         assign valid_o    = acc_vld;
      end
   endgenerate

endmodule

// File: tb/tb_dsp_mac_signed_param.sv
// Directed and model-checked bench for dsp_mac_signed_param across four parameter sets.
module tb_dsp_mac_signed_param;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Default widths, no pipeline registers
   logic               d_sub, d_clr, d_vld;
   logic [19:0]        d_a;
   logic [17:0]        d_b;
   logic signed [39:0] d_p;
   logic               d_ovf, d_vo;

   // Narrow 4x4 -> 8 instances, saturating and wrapping, sharing stimulus
   logic              n_sub, n_clr, n_vld;
   logic [3:0]        n_a, n_b;
   logic signed [7:0] s_p, w_p;
   logic              s_ovf, s_vo, w_ovf, w_vo;

   // Fully pipelined default widths
   logic               p_sub, p_clr, p_vld;
   logic [19:0]        p_a;
   logic [17:0]        p_b;
   logic signed [39:0] p_p;
   logic               p_ovf, p_vo;

   dsp_mac_signed_param u_def (
      .clk(clk), .reset(reset), .subtract_i(d_sub), .clear_i(d_clr), .valid_i(d_vld),
      .A(d_a), .B(d_b), .P(d_p), .overflow_o(d_ovf), .valid_o(d_vo));

   dsp_mac_signed_param #(.A_WIDTH(4), .B_WIDTH(4), .ACC_WIDTH(8), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .subtract_i(n_sub), .clear_i(n_clr), .valid_i(n_vld),
      .A(n_a), .B(n_b), .P(s_p), .overflow_o(s_ovf), .valid_o(s_vo));

   dsp_mac_signed_param #(.A_WIDTH(4), .B_WIDTH(4), .ACC_WIDTH(8), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .subtract_i(n_sub), .clear_i(n_clr), .valid_i(n_vld),
      .A(n_a), .B(n_b), .P(w_p), .overflow_o(w_ovf), .valid_o(w_vo));

   dsp_mac_signed_param #(.IN_REG(1), .OUT_REG(1)) u_pipe (
      .clk(clk), .reset(reset), .subtract_i(p_sub), .clear_i(p_clr), .valid_i(p_vld),
      .A(p_a), .B(p_b), .P(p_p), .overflow_o(p_ovf), .valid_o(p_vo));

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model state for the pipelined instance
   longint      m_acc;
   bit          m_ovf;
   longint      exp_p [32];
   bit          exp_o [32];
   bit          exp_v [32];
   localparam longint ACC_MAX = (64'sd1 <<< 39) - 1;
   localparam longint ACC_MIN = -(64'sd1 <<< 39);

   initial begin
      reset = 1'b1;
      d_sub = 0; d_clr = 0; d_vld = 1; d_a = 20'd5; d_b = 18'd2;
      n_sub = 0; n_clr = 0; n_vld = 0; n_a = '0; n_b = '0;
      p_sub = 0; p_clr = 0; p_vld = 0; p_a = '0; p_b = '0;

      // Reset held over two edges with valid stimulus
      step(); step();
      check("rst_p", d_p, 0);
      check("rst_ovf", d_ovf, 0);
      check("rst_vo", d_vo, 0);
      check("rst_pipe_p", p_p, 0);
      reset = 1'b0;

      step(); check("acc1", d_p, 10); check("acc1_vo", d_vo, 1);
      step(); check("acc2", d_p, 20);
      step(); check("acc3", d_p, 30);
      d_sub = 1;
      step(); check("sub", d_p, 20);

      // Load with subtract, then clear without valid, then hold
      d_clr = 1; d_a = -20'sd3; d_b = 18'sd7;
      step(); check("load", d_p, 21); check("load_ovf", d_ovf, 0);
      d_vld = 0;
      step(); check("clear", d_p, 0);
      d_clr = 0;
      for (int i = 0; i < 3; i++) begin
         step(); check("hold", d_p, 0); check("hold_vo", d_vo, 0);
      end

      // Mid-run reset acts immediately
      d_vld = 1; d_clr = 1; d_sub = 0; d_a = 20'd100; d_b = 18'd10;
      step(); check("pre_rst", d_p, 1000);
      reset = 1'b1;
      #1;
      check("async_rst", d_p, 0);
      check("async_rst_vo", d_vo, 0);
      d_vld = 0; d_clr = 0;
      step();
      reset = 1'b0;

      // Narrow accumulator: saturation versus wrap
      n_vld = 1; n_a = 4'b1000; n_b = 4'b1000;
      step(); check("sat_64", s_p, 64); check("wrap_64", w_p, 64);
      check("sat_ovf0", s_ovf, 0);
      step(); check("sat_clamp", s_p, 127); check("wrap_min", w_p, -128);
      check("sat_ovf1", s_ovf, 1); check("wrap_ovf1", w_ovf, 1);
      n_sub = 1; n_a = 4'd7; n_b = 4'd7;
      step(); check("sat_sub", s_p, 78); check("wrap_sub", w_p, 79);
      check("sat_sticky", s_ovf, 1); check("wrap_sticky", w_ovf, 1);
      n_sub = 0; n_clr = 1; n_vld = 0;
      step(); check("n_clear", s_p, 0); check("n_clear_ovf", s_ovf, 0);
      check("w_clear_ovf", w_ovf, 0);
      n_clr = 0;

      // Pipelined instance against a wrapping model, three edges of latency
      m_acc = 0; m_ovf = 0;
      for (int j = 0; j < 34; j++) begin
         if (j < 32) begin
            longint pa, pb, s;
            logic signed [19:0] ra;
            logic signed [17:0] rb;
            logic signed [39:0] t;
            ra = 20'($urandom);
            rb = 18'($urandom);
            p_a = ra; p_b = rb;
            p_sub = 1'($urandom);
            p_vld = ($urandom_range(0, 3) != 0);
            pa = ra; pb = rb;
            if (p_vld) begin
               s = p_sub ? (m_acc - pa * pb) : (m_acc + pa * pb);
               if (s > ACC_MAX || s < ACC_MIN) m_ovf = 1;
               t = 40'(s);
               m_acc = t;
            end
            exp_p[j] = m_acc;
            exp_o[j] = m_ovf;
            exp_v[j] = p_vld;
         end else begin
            p_vld = 0;
         end
         step();
         if (j >= 2) begin
            check($sformatf("pipe_p[%0d]", j - 2), p_p, exp_p[j-2]);
            check($sformatf("pipe_v[%0d]", j - 2), p_vo, 64'(exp_v[j-2]));
            check($sformatf("pipe_o[%0d]", j - 2), p_ovf, 64'(exp_o[j-2]));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
